// File: rtl/regfile_dump_reader_pkg.sv
// Shared register-file constants and the dump reader state encoding.
// Imported by the register file and by the dump reader.
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);
    localparam int DATA_W   = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        CAPT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Read-port and output-stream bundle of the register dump reader.
// Both channels are valid/ready style: a beat moves on a rising edge where req&gnt or valid&ready are high.
interface regfile_dump_reader_if #(
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DATA_W = regfile_pkg::DATA_W
) ();

    logic              rf_req;
    logic              rf_gnt;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_idx;
    logic              out_last;

    modport master (
        output rf_req, rf_addr, out_valid, out_data, out_idx, out_last,
        input  rf_gnt, rf_data, out_ready
    );

    modport slave (
        input  rf_req, rf_addr, out_valid, out_data, out_idx, out_last,
        output rf_gnt, rf_data, out_ready
    );

endinterface

// File: rtl/regfile_dump_reader.sv
// Walks the register file through a granted read port and streams each word out.
// One word costs at least three cycles: REQ (granted), CAPT, SEND (accepted).
module regfile_dump_reader
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int SKIP_X0  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    regfile_dump_reader_if.master bus,
    output dump_state_t           dbg_state
);

    localparam logic [ADDR_W-1:0] FIRST_IDX = (SKIP_X0 != 0) ? ADDR_W'(1) : '0;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] oidx_q, oidx_d;
    logic              last_q, last_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            oidx_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            oidx_q  <= oidx_d;
            last_q  <= last_d;
        end
    end

    // abort outranks everything, including a same-cycle handshake and a start in IDLE
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        oidx_d  = oidx_q;
        last_d  = last_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = REQ;
                        idx_d   = FIRST_IDX;
                    end
                end
                REQ: begin
                    if (bus.rf_gnt) state_d = CAPT;
                end
                CAPT: begin
                    data_d  = bus.rf_data;
                    oidx_d  = idx_q;
                    last_d  = (idx_q == LAST_IDX);
                    state_d = SEND;
                end
                SEND: begin
                    if (bus.out_ready) begin
                        if (last_q) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + ADDR_W'(1);
                            state_d = REQ;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy          = (state_q != IDLE);
        done          = (state_q == DONE);
        bus.rf_req    = (state_q == REQ);
        bus.rf_addr   = (state_q == REQ) ? idx_q : '0;
        bus.out_valid = (state_q == SEND);
        bus.out_data  = data_q;
        bus.out_idx   = oidx_q;
        bus.out_last  = last_q;
        dbg_state     = state_q;
    end

    a_req_hold: assert property (@(posedge clk) disable iff (rst || abort)
        (state_q == REQ && !bus.rf_gnt) |=> (state_q == REQ && idx_q == $past(idx_q)));

    a_send_hold: assert property (@(posedge clk) disable iff (rst || abort)
        (state_q == SEND && !bus.out_ready) |=>
        (state_q == SEND && data_q == $past(data_q) && oidx_q == $past(oidx_q)));

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Read-side initiator that walks the 32-entry register file through a dedicated read port and streams each register word out on a valid/ready interface.
- Used for debug dump, display and test-harness inspection of architectural state after a program halts.
- Arbitrates politely with the datapath: it reads only while the port is granted, and it never writes.

Parameters:
- NUM_REGS, 32, number of registers scanned; must be a power of two, 2 or greater.
- ADDR_W, 5, register address width; equals log2(NUM_REGS).
- DATA_W, 32, register word width.
- SKIP_X0, 0, when 1 the scan starts at index 1 because x0 is hardwired zero.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a scan; honoured only in IDLE.
- abort  in  1  terminates an active scan; no done pulse follows.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last word is accepted.
- rf_req  out  1  read-port request.
- rf_gnt  in  1  read-port grant from the datapath arbiter.
- rf_addr  out  ADDR_W  register index being read.
- rf_data  in  DATA_W  read data; valid the cycle after a granted request.
- out_valid  out  1  stream word valid.
- out_ready  in  1  stream consumer ready.
- out_data  out  DATA_W  register contents.
- out_idx  out  ADDR_W  register index of out_data.
- out_last  out  1  high with the final word of the scan.

Behaviour:
- Reset (synchronous, active-high; clk and rst only): state=IDLE, idx=0, all outputs 0, out_data=0, out_idx=0.
- States: IDLE, REQ, CAPT, SEND, DONE.
- IDLE:
  - start -> REQ, with idx = SKIP_X0 ? 1 : 0.
  - start arriving in any other state is ignored.
- REQ:
  - rf_req=1, rf_addr=idx.
  - rf_gnt=1 -> CAPT; otherwise stay in REQ indefinitely.
  - rf_addr is held stable while waiting.
- CAPT:
  - rf_req=0.
  - Register rf_data into out_data and idx into out_idx.
  - Set out_last = (idx == NUM_REGS-1).
  - -> SEND.
- SEND:
  - out_valid=1.
  - out_data, out_idx and out_last stay stable until out_valid && out_ready.
  - On that handshake: if out_last -> DONE; else idx = idx+1 -> REQ.
- DONE: done=1 for exactly one cycle -> IDLE.
- Timing:
  - Minimum 3 cycles per word: REQ with an immediate grant, CAPT, then SEND with ready high.
  - Full 32-word scan with no stalls is 96 cycles + 1 DONE cycle.
- abort:
  - Any non-IDLE state -> IDLE on the next edge.
  - out_valid and rf_req drop that edge; done is not asserted.
  - abort takes priority over a same-cycle handshake; the word is counted as not sent.
- Simultaneous start and abort in IDLE: abort wins and the block stays in IDLE.
- idx never wraps: the last index terminates the scan, and the increment happens only when not last.
- out_ready high outside SEND is ignored.
- rst asserted mid-scan has the same result as abort, plus all registered outputs are cleared.

Decomposition:
- Shared package regfile_pkg holds:
  - the NUM_REGS and ADDR_W constants, shared with the register file;
  - the enum dump_state_t {IDLE, REQ, CAPT, SEND, DONE}.
- No sub-module is needed. The output holding register is inline, and the FSM and counter form a single block.

Test Plan:
- Preload reg[i]=32'hA000_0000+i, rf_gnt=1, out_ready=1, start pulse:
  - 32 words, idx 0..31, data A0000000..A000001F.
  - out_last only on idx 31.
  - done 97 cycles after start.
- SKIP_X0=1, same preload -> first word has out_idx=1 and data A0000001; 31 words total.
- rf_gnt low for 5 cycles during idx 7:
  - rf_req and rf_addr=7 held for all 5 cycles.
  - Word 7 data is correct and no word is skipped.
- out_ready low for 10 cycles on idx 3 -> out_data=A0000003 and out_idx=3 stable throughout; exactly one handshake.
- abort asserted during SEND of idx 12 with out_ready=1:
  - The block is in IDLE next cycle.
  - No done pulse, and out_valid=0.
  - A new start restarts the scan at idx 0.
- start pulsed while busy, then rst asserted at idx 20:
  - The second start has no effect.
  - After reset all outputs are 0 and the state is IDLE.
